// File: rtl/toggle_bank_pkg.sv
// -----------------------------------------------------------------------------
// toggle_bank_pkg
//
// Shared types for the toggle_bank block:
//   op_e          - 3-bit command opcode carried on req_op
//   slot_state_e  - occupancy of the single-entry change-event slot
// -----------------------------------------------------------------------------
package toggle_bank_pkg;

    // Command opcodes. OP_RSVD is decoded and treated exactly like OP_NOP.
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_TOGGLE = 3'd1,
        OP_SET    = 3'd2,
        OP_CLEAR  = 3'd3,
        OP_LOAD   = 3'd4,
        OP_LOCK   = 3'd5,
        OP_UNLOCK = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    // The event slot is the only state machine in the block: it either
    // holds an unconsumed change event or it does not.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : toggle_bank_pkg

// File: rtl/toggle_bank_evt_slot.sv
// -----------------------------------------------------------------------------
// toggle_bank_evt_slot
//
// Single-entry, backpressured register that holds the most recent change
// event of toggle_bank until the consumer takes it. It also produces the
// command-side ready, because a new command may only be accepted when the
// slot has room for the event it might create.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   push       in   write a new event this edge (only asserted on accept)
//   push_mask  in   WIDTH  bits that flipped in the new event
//   evt_ready  in   consumer takes the held event this edge
//   evt_valid  out  an event is held
//   evt_mask   out  WIDTH  flipped-bit mask of the held event
//   req_ready  out  the upstream command interface may accept
// -----------------------------------------------------------------------------
module toggle_bank_evt_slot
    import toggle_bank_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_mask,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_mask,
    output logic             req_ready
);

    slot_state_e      state_r;
    slot_state_e      state_nxt;
    logic [WIDTH-1:0] mask_r;
    logic             pop;

    assign pop = (state_r == SLOT_FULL) && evt_ready;

    // Room exists when the slot is empty or is being drained on this edge.
    // This is purely a function of slot state and evt_ready, so it never
    // forms a loop with req_valid.
    assign req_ready = (state_r == SLOT_EMPTY) || evt_ready;

    // NOTE: every variable written in an always_comb gets a default on the
    // first line; any path that skipped an assignment would otherwise infer
    // a latch holding the old value.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (push) begin
                    state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // A concurrent push replaces the popped entry, so the slot
                // only empties when it is drained with nothing arriving.
                if (pop && !push) begin
                    state_nxt = SLOT_EMPTY;
                end
            end
            default: state_nxt = SLOT_EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples its inputs from the same pre-edge values,
    // regardless of the order in which always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_nxt;
        end
    end

    // NOTE: the event mask is reset even though it is qualified by
    // evt_valid, so its post-reset value is defined rather than X; it is a
    // single register, not a storage array, so the reset costs nothing
    // meaningful.
    // The mask is written only on push; with no push it holds, which keeps
    // it stable while the consumer is stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= '0;
        end else if (push) begin
            mask_r <= push_mask;
        end
    end

    assign evt_valid = (state_r == SLOT_FULL);
    assign evt_mask  = mask_r;

endmodule : toggle_bank_evt_slot

// File: rtl/toggle_bank.sv
// -----------------------------------------------------------------------------
// toggle_bank
//
// Bank of WIDTH toggle/set/clear flip-flops with per-bit lock bits, driven
// through a valid/ready command interface. Every accepted command that
// actually flips at least one state bit emits a change event (the mask of
// flipped bits) into a single-entry backpressured slot and bumps a
// saturating change counter. Used to hold board-cell and turn state for the
// game logic; with WIDTH = 1 it is a T flip-flop with lock and reporting.
//
// Parameters:
//   WIDTH      number of state bits (>= 1)
//   RESET_VAL  value of q after reset
//   CNT_W      width of change_cnt (>= 1)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   req_valid   in   command present
//   req_ready   out  command can be accepted this cycle
//   req_op      in   3    opcode (toggle_bank_pkg::op_e)
//   req_mask    in   WIDTH  bits addressed by the command
//   req_data    in   WIDTH  data for LOAD
//   q           out  WIDTH  current state bits
//   lock        out  WIDTH  current lock bits
//   evt_valid   out  change event pending
//   evt_ready   in   consumer takes the event
//   evt_mask    out  WIDTH  bits that flipped in the reported change
//   change_cnt  out  CNT_W  number of events emitted, saturating
// -----------------------------------------------------------------------------
module toggle_bank
    import toggle_bank_pkg::*;
#(
    parameter int               WIDTH     = 9,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] lock,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [CNT_W-1:0] change_cnt
);

    op_e              op;
    logic             accept;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] lock_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] eff_mask;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] lock_nxt;
    logic [WIDTH-1:0] delta;
    logic             change;

    assign op     = op_e'(req_op);
    assign accept = req_valid && req_ready;

    // Next-state decode. Data ops are gated by the lock bits; LOCK/UNLOCK
    // deliberately use the raw mask so a locked bit can always be unlocked.
    always_comb begin
        eff_mask = req_mask & ~lock_r;
        q_nxt    = q_r;
        lock_nxt = lock_r;
        case (op)
            OP_TOGGLE: q_nxt    = q_r ^ eff_mask;
            OP_SET:    q_nxt    = q_r | eff_mask;
            OP_CLEAR:  q_nxt    = q_r & ~eff_mask;
            OP_LOAD:   q_nxt    = (q_r & ~eff_mask) | (req_data & eff_mask);
            OP_LOCK:   lock_nxt = lock_r | req_mask;
            OP_UNLOCK: lock_nxt = lock_r & ~req_mask;
            default:   ; // OP_NOP and OP_RSVD leave everything unchanged
        endcase
    end

    // Lock ops never touch q, so a nonzero delta alone identifies a data op
    // that really changed something; no-op writes produce no event.
    assign delta  = q_r ^ q_nxt;
    assign change = accept && (delta != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= RESET_VAL;
            lock_r <= '0;
        end else if (accept) begin
            q_r    <= q_nxt;
            lock_r <= lock_nxt;
        end
    end

    // Counts emitted events; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (change && (cnt_r != '1)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    toggle_bank_evt_slot #(
        .WIDTH (WIDTH)
    ) u_evt_slot (
        .clk       (clk),
        .reset     (reset),
        .push      (change),
        .push_mask (delta),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_mask  (evt_mask),
        .req_ready (req_ready)
    );

    assign q          = q_r;
    assign lock       = lock_r;
    assign change_cnt = cnt_r;

endmodule : toggle_bank

// File: tb/tb_toggle_bank.sv
// -----------------------------------------------------------------------------
// tb_toggle_bank
//
// Directed bench for toggle_bank. Instance u_dut_a uses RESET_VAL = 9'h0A5
// and an 8-bit counter; u_dut_b uses RESET_VAL = 0 and a 2-bit counter to
// exercise counter saturation. Inputs change 1 ns after a rising edge and
// outputs are sampled there, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_toggle_bank;
    import toggle_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       a_reset;
    logic       a_req_valid;
    logic       a_req_ready;
    logic [2:0] a_req_op;
    logic [8:0] a_req_mask;
    logic [8:0] a_req_data;
    logic [8:0] a_q;
    logic [8:0] a_lock;
    logic       a_evt_valid;
    logic       a_evt_ready;
    logic [8:0] a_evt_mask;
    logic [7:0] a_change_cnt;

    // Instance B signals
    logic       b_reset;
    logic       b_req_valid;
    logic       b_req_ready;
    logic [2:0] b_req_op;
    logic [8:0] b_req_mask;
    logic [8:0] b_req_data;
    logic [8:0] b_q;
    logic [8:0] b_lock;
    logic       b_evt_valid;
    logic       b_evt_ready;
    logic [8:0] b_evt_mask;
    logic [1:0] b_change_cnt;

    int n_vec = 0;
    int n_err = 0;

    toggle_bank #(
        .WIDTH     (9),
        .RESET_VAL (9'h0A5),
        .CNT_W     (8)
    ) u_dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_op     (a_req_op),
        .req_mask   (a_req_mask),
        .req_data   (a_req_data),
        .q          (a_q),
        .lock       (a_lock),
        .evt_valid  (a_evt_valid),
        .evt_ready  (a_evt_ready),
        .evt_mask   (a_evt_mask),
        .change_cnt (a_change_cnt)
    );

    toggle_bank #(
        .WIDTH     (9),
        .RESET_VAL (9'h000),
        .CNT_W     (2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_op     (b_req_op),
        .req_mask   (b_req_mask),
        .req_data   (b_req_data),
        .q          (b_q),
        .lock       (b_lock),
        .evt_valid  (b_evt_valid),
        .evt_ready  (b_evt_ready),
        .evt_mask   (b_evt_mask),
        .change_cnt (b_change_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input op_e o, input logic [8:0] m, input logic [8:0] d);
        a_req_valid = v;
        a_req_op    = o;
        a_req_mask  = m;
        a_req_data  = d;
    endtask

    initial begin
        a_reset = 1'b1;  a_evt_ready = 1'b1;
        drive_a(1'b0, OP_NOP, 9'h000, 9'h000);
        b_reset = 1'b1;  b_evt_ready = 1'b1;
        b_req_valid = 1'b0; b_req_op = OP_NOP; b_req_mask = '0; b_req_data = '0;

        // ---- Reset state --------------------------------------------------
        tick(); tick();
        check("rst_q",     32'(a_q),          32'h0A5);
        check("rst_lock",  32'(a_lock),       32'h000);
        check("rst_evtv",  32'(a_evt_valid),  32'h0);
        check("rst_evtm",  32'(a_evt_mask),   32'h000);
        check("rst_cnt",   32'(a_change_cnt), 32'h0);
        check("rst_ready", 32'(a_req_ready),  32'h1);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // ---- Clear to zero: delta = 0x0A5 --------------------------------
        drive_a(1'b1, OP_CLEAR, 9'h1FF, 9'h000);
        tick();
        check("clr_q",    32'(a_q),          32'h000);
        check("clr_evtm", 32'(a_evt_mask),   32'h0A5);
        check("clr_cnt",  32'(a_change_cnt), 32'h1);

        // ---- Back-to-back TOGGLE 0x003 -----------------------------------
        drive_a(1'b1, OP_TOGGLE, 9'h003, 9'h000);
        tick();
        check("tg1_q",    32'(a_q),          32'h003);
        check("tg1_evtv", 32'(a_evt_valid),  32'h1);
        check("tg1_evtm", 32'(a_evt_mask),   32'h003);
        check("tg1_cnt",  32'(a_change_cnt), 32'h2);
        tick();
        check("tg2_q",    32'(a_q),          32'h000);
        check("tg2_evtm", 32'(a_evt_mask),   32'h003);
        check("tg2_cnt",  32'(a_change_cnt), 32'h3);
        drive_a(1'b0, OP_NOP, 9'h000, 9'h000);
        tick();
        check("idle_evtv", 32'(a_evt_valid),  32'h0);
        check("idle_cnt",  32'(a_change_cnt), 32'h3);

        // ---- Lock bit 4, then SET all, then CLEAR the locked bit ---------
        drive_a(1'b1, OP_LOCK, 9'h010, 9'h000);
        tick();
        check("lock_lock", 32'(a_lock),      32'h010);
        check("lock_evtv", 32'(a_evt_valid), 32'h0);
        drive_a(1'b1, OP_SET, 9'h1FF, 9'h000);
        tick();
        check("set_q",    32'(a_q),          32'h1EF);
        check("set_evtm", 32'(a_evt_mask),   32'h1EF);
        check("set_cnt",  32'(a_change_cnt), 32'h4);
        drive_a(1'b1, OP_CLEAR, 9'h010, 9'h000);
        tick();
        check("clrlk_q",    32'(a_q),          32'h1EF);
        check("clrlk_evtv", 32'(a_evt_valid),  32'h0);
        check("clrlk_cnt",  32'(a_change_cnt), 32'h4);

        // ---- All-zero mask is accepted but silent ------------------------
        drive_a(1'b1, OP_TOGGLE, 9'h000, 9'h000);
        tick();
        check("zm_q",    32'(a_q),          32'h1EF);
        check("zm_evtv", 32'(a_evt_valid),  32'h0);
        check("zm_cnt",  32'(a_change_cnt), 32'h4);

        // ---- Reserved opcode behaves as NOP ------------------------------
        drive_a(1'b1, OP_RSVD, 9'h1FF, 9'h1FF);
        tick();
        check("rsv_q",    32'(a_q),         32'h1EF);
        check("rsv_lock", 32'(a_lock),      32'h010);
        check("rsv_evtv", 32'(a_evt_valid), 32'h0);

        // ---- Unlock, then the bit toggles again --------------------------
        drive_a(1'b1, OP_UNLOCK, 9'h010, 9'h000);
        tick();
        check("unlk_lock", 32'(a_lock), 32'h000);
        drive_a(1'b1, OP_TOGGLE, 9'h010, 9'h000);
        tick();
        check("tgu_q",    32'(a_q),          32'h1FF);
        check("tgu_evtm", 32'(a_evt_mask),   32'h010);
        check("tgu_cnt",  32'(a_change_cnt), 32'h5);

        // ---- Backpressure: SET 0x001 then LOAD with evt_ready low --------
        drive_a(1'b1, OP_CLEAR, 9'h1FF, 9'h000);
        tick();
        check("pre_q",   32'(a_q),          32'h000);
        check("pre_cnt", 32'(a_change_cnt), 32'h6);
        drive_a(1'b0, OP_NOP, 9'h000, 9'h000);
        tick();
        a_evt_ready = 1'b0;
        drive_a(1'b1, OP_SET, 9'h001, 9'h000);
        tick();
        check("bp1_q",     32'(a_q),          32'h001);
        check("bp1_evtv",  32'(a_evt_valid),  32'h1);
        check("bp1_evtm",  32'(a_evt_mask),   32'h001);
        check("bp1_cnt",   32'(a_change_cnt), 32'h7);
        check("bp1_ready", 32'(a_req_ready),  32'h0);
        drive_a(1'b1, OP_LOAD, 9'h0F0, 9'h0A0);
        tick();
        check("stall_q",     32'(a_q),          32'h001);
        check("stall_evtm",  32'(a_evt_mask),   32'h001);
        check("stall_cnt",   32'(a_change_cnt), 32'h7);
        check("stall_ready", 32'(a_req_ready),  32'h0);
        a_evt_ready = 1'b1;
        #1;
        check("pop_ready", 32'(a_req_ready), 32'h1);
        check("pop_evtm",  32'(a_evt_mask),  32'h001);
        tick();
        check("ld_q",    32'(a_q),          32'h0A1);
        check("ld_evtv", 32'(a_evt_valid),  32'h1);
        check("ld_evtm", 32'(a_evt_mask),   32'h0A0);
        check("ld_cnt",  32'(a_change_cnt), 32'h8);

        // ---- Reset with a pending event and a pending command ------------
        a_evt_ready = 1'b0;
        drive_a(1'b1, OP_TOGGLE, 9'h001, 9'h000);
        a_reset = 1'b1;
        tick();
        check("rst2_q",     32'(a_q),          32'h0A5);
        check("rst2_lock",  32'(a_lock),       32'h000);
        check("rst2_evtv",  32'(a_evt_valid),  32'h0);
        check("rst2_cnt",   32'(a_change_cnt), 32'h0);
        check("rst2_ready", 32'(a_req_ready),  32'h1);
        drive_a(1'b0, OP_NOP, 9'h000, 9'h000);
        a_reset = 1'b0;
        tick();
        check("rst2_hold_q", 32'(a_q), 32'h0A5);

        // ---- Counter saturation on a 2-bit counter -----------------------
        b_req_valid = 1'b1;
        b_req_op    = OP_TOGGLE;
        b_req_mask  = 9'h001;
        tick();
        check("sat1_cnt", 32'(b_change_cnt), 32'h1);
        check("sat1_q",   32'(b_q),          32'h001);
        tick();
        check("sat2_cnt", 32'(b_change_cnt), 32'h2);
        check("sat2_q",   32'(b_q),          32'h000);
        tick();
        check("sat3_cnt", 32'(b_change_cnt), 32'h3);
        tick();
        check("sat4_cnt", 32'(b_change_cnt), 32'h3);
        check("sat4_q",   32'(b_q),          32'h000);
        tick();
        check("sat5_cnt",  32'(b_change_cnt), 32'h3);
        check("sat5_q",    32'(b_q),          32'h001);
        check("sat5_evtv", 32'(b_evt_valid),  32'h1);
        b_req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_toggle_bank
